// File: rtl/swan128_pkg.sv
// SWAN128 shared constants and key-schedule FSM encoding.
// Imported by the key-schedule controller and its step function.
package swan128_pkg;

  localparam int unsigned BLOCK_SIZE = 128;
  localparam int unsigned KEY_SIZE   = 256;
  localparam int unsigned ROUNDS     = 64;
  localparam int unsigned PD         = 56;
  localparam logic [63:0] DELTA0     = 64'h9e3779b97f4a7c15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ks_state_t;

endpackage

// File: rtl/enc_key_schedule_256.sv
// SWAN128 single-round key-schedule step.
// Rotate key, bump delta, derive subkey and fold it back in.
module enc_key_schedule_256 #(
  parameter int unsigned KEY_SIZE = 256,
  parameter int unsigned SK_W     = 64,
  parameter int unsigned PD       = 56,
  parameter logic [63:0] DELTA0   = 64'h9e3779b97f4a7c15
) (
  input  logic [KEY_SIZE-1:0] key,
  input  logic [63:0]         delta,
  output logic [KEY_SIZE-1:0] next_key,
  output logic [63:0]         next_delta,
  output logic [SK_W-1:0]     sk
);

  logic [KEY_SIZE-1:0] k0;

  // Pure combinational step; the controller registers the results.
  always_comb begin
    k0         = {key[PD-1:0], key[KEY_SIZE-1:PD]};
    next_delta = delta + DELTA0;
    sk         = k0[SK_W-1:0] + next_delta[SK_W-1:0];
    next_key   = {k0[KEY_SIZE-1:SK_W], sk};
  end

endmodule

// File: rtl/swan128_key_sched_ctrl.sv
// SWAN128 key-schedule sequencer.
// Latches the master key and streams ROUNDS subkeys over valid/ready.
module swan128_key_sched_ctrl
  import swan128_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = swan128_pkg::BLOCK_SIZE,
  parameter int unsigned KEY_SIZE   = swan128_pkg::KEY_SIZE,
  parameter int unsigned ROUNDS     = swan128_pkg::ROUNDS,
  parameter int unsigned PD         = swan128_pkg::PD,
  parameter logic [63:0] DELTA0     = swan128_pkg::DELTA0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [KEY_SIZE-1:0]     key_in,
  output logic                    busy,
  output logic                    sk_valid,
  input  logic                    sk_ready,
  output logic [BLOCK_SIZE/2-1:0] sk,
  output logic [7:0]              sk_round,
  output logic                    done
);

  localparam int unsigned SK_W = BLOCK_SIZE / 2;
  localparam logic [7:0] LAST = 8'(ROUNDS - 1);

  ks_state_t           state;
  logic [KEY_SIZE-1:0] key_r;
  logic [63:0]         delta_r;
  logic [7:0]          round_r;
  logic [KEY_SIZE-1:0] nk;
  logic [63:0]         nd;
  logic [SK_W-1:0]     sk_w;
  logic                hs;

  enc_key_schedule_256 #(
    .KEY_SIZE (KEY_SIZE),
    .SK_W     (SK_W),
    .PD       (PD),
    .DELTA0   (DELTA0)
  ) u_step (
    .key        (key_r),
    .delta      (delta_r),
    .next_key   (nk),
    .next_delta (nd),
    .sk         (sk_w)
  );

  assign hs       = sk_valid & sk_ready;
  assign sk       = sk_w;
  assign sk_round = round_r;

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      key_r    <= '0;
      delta_r  <= '0;
      round_r  <= '0;
      busy     <= 1'b0;
      sk_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            key_r    <= key_in;
            delta_r  <= '0;
            round_r  <= '0;
            busy     <= 1'b1;
            sk_valid <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            busy     <= 1'b0;
            sk_valid <= 1'b0;
            state    <= ST_IDLE;
          end else if (hs) begin
            key_r   <= nk;
            delta_r <= nd;
            round_r <= round_r + 8'd1;
            if (round_r == LAST) begin
              sk_valid <= 1'b0;
              done     <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy     <= 1'b0;
          sk_valid <= 1'b0;
          done     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swan128_key_sched_ctrl.sv
// Directed bench for swan128_key_sched_ctrl.
// Default build plus a ROUNDS=1 build sharing clk/rst.
module tb_swan128_key_sched_ctrl;

  localparam logic [63:0] D0 = 64'h9e3779b97f4a7c15;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [255:0] key_in = '0;
  logic         busy;
  logic         sk_valid;
  logic         sk_ready = 1'b0;
  logic [63:0]  sk;
  logic [7:0]   sk_round;
  logic         done;

  logic         start1 = 1'b0;
  logic         abort1 = 1'b0;
  logic         busy1;
  logic         sk_valid1;
  logic         sk_ready1 = 1'b0;
  logic [63:0]  sk1;
  logic [7:0]   sk_round1;
  logic         done1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  swan128_key_sched_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .key_in   (key_in),
    .busy     (busy),
    .sk_valid (sk_valid),
    .sk_ready (sk_ready),
    .sk       (sk),
    .sk_round (sk_round),
    .done     (done)
  );

  swan128_key_sched_ctrl #(.ROUNDS(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start1),
    .abort    (abort1),
    .key_in   (key_in),
    .busy     (busy1),
    .sk_valid (sk_valid1),
    .sk_ready (sk_ready1),
    .sk       (sk1),
    .sk_round (sk_round1),
    .done     (done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_step(
    input  logic [255:0] k,
    input  logic [63:0]  d,
    output logic [255:0] nk,
    output logic [63:0]  nd,
    output logic [63:0]  s
  );
    logic [255:0] k0;
    k0 = (k >> 56) | (k << 200);
    nd = d + D0;
    s  = k0[63:0] + nd;
    nk = {k0[255:64], s};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (busy !== 1'b0 || sk_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags busy=%b v=%b done=%b want 0 0 0",
               busy, sk_valid, done);
    end
    n_tests++;
    if (sk_round !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_round got %0d want 0", sk_round);
    end
    n_tests++;
    if ((^sk) === 1'bx) begin
      n_fail++;
      $display("FAIL reset_sk_x got %h want non-X", sk);
    end
    n_tests++;
    if (busy1 !== 1'b0 || sk_valid1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_r1 busy=%b v=%b done=%b want 0 0 0",
               busy1, sk_valid1, done1);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_key();
    logic [255:0] mk, nk;
    logic [63:0]  md, nd, ms;
    int n, cyc;
    key_in = '0;
    sk_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    mk = '0; md = '0; n = 0; cyc = 0;
    while (sk_valid === 1'b1 && cyc < 200) begin
      model_step(mk, md, nk, nd, ms);
      n_tests++;
      if (sk !== ms || sk_round !== 8'(n)) begin
        n_fail++;
        $display("FAIL zero_sk r=%0d got %h/%0d want %h/%0d",
                 n, sk, sk_round, ms, n);
      end
      if (n == 0) begin
        n_tests++;
        if (sk !== 64'h9e3779b97f4a7c15) begin
          n_fail++;
          $display("FAIL zero_sk0 got %h want 9e3779b97f4a7c15", sk);
        end
      end
      if (n == 1) begin
        n_tests++;
        if (sk !== 64'h3c6ef372fe94f8c8) begin
          n_fail++;
          $display("FAIL zero_sk1 got %h want 3c6ef372fe94f8c8", sk);
        end
      end
      mk = nk; md = nd; n++;
      tick();
      cyc++;
    end
    n_tests++;
    if (n != 64) begin
      n_fail++;
      $display("FAIL zero_count got %0d handshakes want 64", n);
    end
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done done=%b busy=%b want 1 1", done, busy);
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || sk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_idle done=%b busy=%b v=%b want 0 0 0",
               done, busy, sk_valid);
    end
    sk_ready = 1'b0;
    tick();
  endtask

  task automatic test_random_stall();
    logic [255:0] mk, nk;
    logic [63:0]  md, nd, ms;
    int n, cyc;
    logic r;
    key_in = rand256();
    mk = key_in; md = '0; n = 0; cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (n < 64 && cyc < 1000) begin
      model_step(mk, md, nk, nd, ms);
      n_tests++;
      if (sk_valid !== 1'b1 || sk !== ms || sk_round !== 8'(n)) begin
        n_fail++;
        $display("FAIL stall_sk r=%0d got v=%b %h/%0d want 1 %h/%0d",
                 n, sk_valid, sk, sk_round, ms, n);
      end
      r = 1'($urandom % 2);
      sk_ready = r;
      if (r) begin
        mk = nk; md = nd; n++;
      end
      tick();
      cyc++;
    end
    sk_ready = 1'b0;
    n_tests++;
    if (n != 64 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_done n=%0d done=%b want 64 1", n, done);
    end
    tick();
    tick();
  endtask

  task automatic test_abort();
    int cyc;
    key_in = rand256();
    sk_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (sk_round !== 8'd10 && cyc < 50) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (sk_round !== 8'd10 || sk_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reach round=%0d v=%b want 10 1", sk_round, sk_valid);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || sk_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle busy=%b v=%b done=%b want 0 0 0",
               busy, sk_valid, done);
    end
    n_tests++;
    if (sk_round !== 8'd10) begin
      n_fail++;
      $display("FAIL abort_nohs round=%0d want 10", sk_round);
    end
    tick();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_nodone done=%b want 0", done);
    end
    key_in = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (sk_round !== 8'd0 || sk !== 64'h9e3779b97f4a7c15) begin
      n_fail++;
      $display("FAIL abort_restart got %0d/%h want 0/9e3779b97f4a7c15",
               sk_round, sk);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sk_ready = 1'b0;
    tick();
  endtask

  task automatic test_start_held();
    logic [255:0] ka, kb, mk, nk;
    logic [63:0]  md, nd, ms;
    int n, cyc;
    ka = rand256();
    kb = rand256();
    key_in = ka;
    sk_ready = 1'b1;
    start = 1'b1;
    tick();
    key_in = kb;
    mk = ka; md = '0; n = 0; cyc = 0;
    while (sk_valid === 1'b1 && cyc < 200) begin
      model_step(mk, md, nk, nd, ms);
      n_tests++;
      if (sk !== ms || sk_round !== 8'(n)) begin
        n_fail++;
        $display("FAIL held_sk r=%0d got %h/%0d want %h/%0d",
                 n, sk, sk_round, ms, n);
      end
      mk = nk; md = nd; n++;
      tick();
      cyc++;
    end
    n_tests++;
    if (n != 64 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL held_done n=%0d done=%b want 64 1", n, done);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL held_idle busy=%b done=%b want 0 0", busy, done);
    end
    tick();
    start = 1'b0;
    model_step(kb, 64'd0, nk, nd, ms);
    n_tests++;
    if (busy !== 1'b1 || sk_round !== 8'd0 || sk !== ms) begin
      n_fail++;
      $display("FAIL held_restart busy=%b %0d/%h want 1 0/%h",
               busy, sk_round, sk, ms);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sk_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    key_in = rand256();
    sk_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || sk_valid !== 1'b0 || done !== 1'b0 ||
        sk_round !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_mid busy=%b v=%b done=%b round=%0d want 0 0 0 0",
               busy, sk_valid, done, sk_round);
    end
    start = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0 || sk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_start_ign busy=%b v=%b want 0 0", busy, sk_valid);
    end
    sk_ready = 1'b0;
  endtask

  task automatic test_rounds1();
    key_in = '0;
    sk_ready1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n_tests++;
    if (sk_valid1 !== 1'b1 || sk1 !== 64'h9e3779b97f4a7c15 ||
        sk_round1 !== 8'd0) begin
      n_fail++;
      $display("FAIL r1_sk v=%b %h/%0d want 1 9e3779b97f4a7c15/0",
               sk_valid1, sk1, sk_round1);
    end
    tick();
    n_tests++;
    if (done1 !== 1'b1 || sk_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL r1_done done=%b v=%b want 1 0", done1, sk_valid1);
    end
    tick();
    n_tests++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL r1_idle done=%b busy=%b want 0 0", done1, busy1);
    end
    sk_ready1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_key();
    test_random_stall();
    test_abort();
    test_start_held();
    test_reset_mid();
    test_rounds1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
